fx3_stream_out_capture: RTL and testbench

Sits directly downstream of the FX3 slave-FIFO stream-OUT read controller.
- Realigns that controller's per-cycle `reading` strobe with the FX3's fixed read-data latency.
- Captures each valid 32-bit word from the GPIF data bus into a local FWFT FIFO.
- Presents the words to the consumer on a valid/ready interface.
- Returns a registered `space_ok` level that gates the controller's `stream_out_mode_selected`, so the FX3 is never read faster than the consumer drains.

---
 rtl/fx3_pkg.sv | 7 +
 rtl/sync_fifo_fwft.sv | 60 ++++++
 rtl/fx3_stream_out_capture.sv | 95 +++++++++
 tb/tb_fx3_stream_out_capture.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fx3_pkg.sv
// Shared FX3 stream-OUT definitions: bus width, default read latency and the word type.
package fx3_pkg;
   localparam int FX3_DW                 = 32;
   localparam int FX3_RD_LATENCY_DEFAULT = 2;

   typedef logic [FX3_DW-1:0] fx3_word_t;
endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO with extra-MSB pointers and a registered level.
module sync_fifo_fwft #(
   parameter  int DW    = 32,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk_100,
   input  logic          reset_,
   input  logic          push,
   input  logic [DW-1:0] din,
   input  logic          pop,
   output logic [DW-1:0] dout,
   output logic          empty,
   output logic          full,
   output logic [AW:0]   level
);

   logic [DW-1:0] r_mem [DEPTH];
   logic [AW:0]   r_wptr;
   logic [AW:0]   r_rptr;
   logic [AW:0]   r_level;
   logic          w_doPush;
   logic          w_doPop;

   // A pop frees the slot on the same edge, so a push into a full FIFO still lands if a pop accompanies it.
   assign w_doPop  = pop & ~empty;
   assign w_doPush = push & (~full | w_doPop);

   assign empty = (r_wptr == r_rptr);
   assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign dout  = r_mem[r_rptr[AW-1:0]];
   assign level = r_level;

   always_ff @(posedge clk_100) begin
      if (w_doPush) begin
         r_mem[r_wptr[AW-1:0]] <= din;
      end
   end

   always_ff @(posedge clk_100 or negedge reset_) begin
      if (!reset_) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_doPush) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_doPop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         case ({w_doPush, w_doPop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/fx3_stream_out_capture.sv
// Realigns the FX3 read strobe with the bus read latency, captures words into a FWFT FIFO
// and returns a registered space_ok level that throttles the stream-OUT read controller.
module fx3_stream_out_capture
   import fx3_pkg::*;
#(
   parameter  int RD_LATENCY   = FX3_RD_LATENCY_DEFAULT,
   parameter  int DEPTH        = 16,
   parameter  int AFULL_MARGIN = 4,
   localparam int LW           = $clog2(DEPTH) + 1
) (
   input  logic          clk_100,
   input  logic          reset_,
   input  logic          reading_i,
   input  fx3_word_t     data_i,
   output logic          space_ok,
   output fx3_word_t     m_data,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [LW-1:0] level,
   output logic          overflow
);

   localparam int THRESH = DEPTH - AFULL_MARGIN;

   if (RD_LATENCY < 1 || RD_LATENCY > 4 || DEPTH < 8 || (DEPTH & (DEPTH - 1)) != 0 ||
       AFULL_MARGIN < RD_LATENCY + 2) begin : g_paramCheck
      $error("fx3_stream_out_capture: illegal parameter combination");
   end

   logic [RD_LATENCY-1:0] r_vpipe;
   logic [RD_LATENCY-1:0] w_vpipeNext;
   logic                  r_spaceOk;
   logic                  r_overflow;
   logic                  w_push;
   logic                  w_empty;
   logic                  w_full;
   logic                  w_doPop;
   logic                  w_doPush;
   logic [LW-1:0]         w_level;
   logic [LW:0]           w_levelNext;
   logic [LW:0]           w_inflightNext;
   logic [LW:0]           w_committed;

   assign w_vpipeNext = RD_LATENCY'({r_vpipe, reading_i});
   assign w_push      = r_vpipe[RD_LATENCY-1];

   assign w_doPop     = ~w_empty & m_ready;
   assign w_doPush    = w_push & (~w_full | w_doPop);
   assign w_levelNext = {1'b0, w_level} + (LW+1)'(w_doPush) - (LW+1)'(w_doPop);

   // Words already strobed but not yet on the bus must be counted against free space.
   always_comb begin
      w_inflightNext = '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
         w_inflightNext = w_inflightNext + (LW+1)'(w_vpipeNext[i]);
      end
   end

   assign w_committed = w_levelNext + w_inflightNext;

   always_ff @(posedge clk_100 or negedge reset_) begin
      if (!reset_) begin
         r_vpipe    <= '0;
         r_spaceOk  <= 1'b1;
         r_overflow <= 1'b0;
      end else begin
         r_vpipe   <= w_vpipeNext;
         r_spaceOk <= (w_committed <= (LW+1)'(THRESH));
         if (w_push && w_full && !w_doPop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   sync_fifo_fwft #(
      .DW    (FX3_DW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_100 (clk_100),
      .reset_  (reset_),
      .push    (w_push),
      .din     (data_i),
      .pop     (w_doPop),
      .dout    (m_data),
      .empty   (w_empty),
      .full    (w_full),
      .level   (w_level)
   );

   assign m_valid  = ~w_empty;
   assign level    = w_level;
   assign space_ok = r_spaceOk;
   assign overflow = r_overflow;

endmodule

// File: tb/tb_fx3_stream_out_capture.sv
// Directed bench for fx3_stream_out_capture: default instance (latency 2) plus a latency-3 instance.
module tb_fx3_stream_out_capture;

   logic        clk_100;
   logic        reset_;
   logic        reading_i;
   logic [31:0] data_i;
   logic        space_ok;
   logic [31:0] m_data;
   logic        m_valid;
   logic        m_ready;
   logic [4:0]  level;
   logic        overflow;

   logic        reading3;
   logic [31:0] data3;
   logic        spaceOk3;
   logic [31:0] mData3;
   logic        mValid3;
   logic [4:0]  level3;
   logic        overflow3;

   int testsRun;
   int testsFailed;

   fx3_stream_out_capture #(
      .RD_LATENCY   (2),
      .DEPTH        (16),
      .AFULL_MARGIN (4)
   ) u_dut (
      .clk_100   (clk_100),
      .reset_    (reset_),
      .reading_i (reading_i),
      .data_i    (data_i),
      .space_ok  (space_ok),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .level     (level),
      .overflow  (overflow)
   );

   fx3_stream_out_capture #(
      .RD_LATENCY   (3),
      .DEPTH        (16),
      .AFULL_MARGIN (5)
   ) u_dut3 (
      .clk_100   (clk_100),
      .reset_    (reset_),
      .reading_i (reading3),
      .data_i    (data3),
      .space_ok  (spaceOk3),
      .m_data    (mData3),
      .m_valid   (mValid3),
      .m_ready   (1'b0),
      .level     (level3),
      .overflow  (overflow3)
   );

   initial clk_100 = 1'b0;
   always #5 clk_100 = ~clk_100;

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk_100);
      #1;
   endtask

   task automatic applyReset();
      reset_    = 1'b0;
      reading_i = 1'b0;
      data_i    = '0;
      m_ready   = 1'b0;
      reading3  = 1'b0;
      data3     = '0;
      tick();
      tick();
      reset_ = 1'b1;
   endtask

   task automatic test_reset();
      reset_    = 1'b0;
      reading_i = 1'b0;
      m_ready   = 1'b0;
      reading3  = 1'b0;
      tick();
      testsRun++;
      if (m_valid !== 1'b0 || level !== 5'd0 || space_ok !== 1'b1 || overflow !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL reset_state: got valid=%b level=%0d space_ok=%b ovf=%b required 0 0 1 0",
                  m_valid, level, space_ok, overflow);
      end
      testsRun++;
      if (mValid3 !== 1'b0 || level3 !== 5'd0 || spaceOk3 !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL reset_state_lat3: got valid=%b level=%0d space_ok=%b required 0 0 1",
                  mValid3, level3, spaceOk3);
      end
   endtask

   task automatic test_latency();
      applyReset();
      for (int c = 1; c <= 16; c++) begin
         reading_i = (c >= 10 && c <= 12);
         data_i    = 32'hA000_0000 + 32'(c);
         tick();
         if (c == 11) begin
            testsRun++;
            if (m_valid !== 1'b0) begin
               testsFailed++;
               $display("[TB] FAIL lat_valid_early: got %b required 0", m_valid);
            end
         end
         if (c == 12) begin
            testsRun++;
            if (m_valid !== 1'b1 || m_data !== 32'hA000_000C) begin
               testsFailed++;
               $display("[TB] FAIL lat_first_word: got valid=%b data=%h required 1 a000000c", m_valid, m_data);
            end
         end
         if (c == 14) begin
            testsRun++;
            if (level !== 5'd3 || m_data !== 32'hA000_000C) begin
               testsFailed++;
               $display("[TB] FAIL lat_level3: got level=%0d data=%h required 3 a000000c", level, m_data);
            end
         end
      end
      m_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         testsRun++;
         if (m_valid !== 1'b1 || m_data !== 32'hA000_000C + 32'(i)) begin
            testsFailed++;
            $display("[TB] FAIL lat_drain%0d: got valid=%b data=%h required 1 %h",
                     i, m_valid, m_data, 32'hA000_000C + 32'(i));
         end
         tick();
      end
      m_ready = 1'b0;
   endtask

   task automatic test_flow_control();
      logic prevS;
      logic s;
      bit   fell;
      applyReset();
      reading_i = 1'b1;
      prevS     = 1'b1;
      fell      = 1'b0;
      for (int k = 1; k <= 30; k++) begin
         data_i = 32'h5000_0000 + 32'(k);
         tick();
         s = space_ok;
         if (!fell && !s) begin
            fell = 1'b1;
            testsRun++;
            if (k != 13 || level !== 5'd11) begin
               testsFailed++;
               $display("[TB] FAIL fc_fall_point: got edge=%0d level=%0d required edge 13 level 11", k, level);
            end
         end
         reading_i = prevS;
         prevS     = s;
      end
      reading_i = 1'b0;
      tick();
      tick();
      testsRun++;
      if (!fell) begin
         testsFailed++;
         $display("[TB] FAIL fc_never_fell: got space_ok never low required a fall");
      end
      testsRun++;
      if (level !== 5'd14 || overflow !== 1'b0 || space_ok !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL fc_final: got level=%0d ovf=%b space_ok=%b required 14 0 0", level, overflow, space_ok);
      end
   endtask

   task automatic test_full_push();
      logic [31:0] exp;
      applyReset();
      for (int c = 1; c <= 24; c++) begin
         reading_i = (c <= 16) || (c == 19) || (c == 22);
         m_ready   = (c == 21);
         data_i    = 32'hB000_0000 + 32'(c);
         tick();
         if (c == 18) begin
            testsRun++;
            if (level !== 5'd16) begin
               testsFailed++;
               $display("[TB] FAIL full_fill: got level=%0d required 16", level);
            end
         end
         if (c == 21) begin
            testsRun++;
            if (level !== 5'd16 || overflow !== 1'b0) begin
               testsFailed++;
               $display("[TB] FAIL full_push_pop: got level=%0d ovf=%b required 16 0", level, overflow);
            end
         end
         if (c == 24) begin
            testsRun++;
            if (level !== 5'd16 || overflow !== 1'b1) begin
               testsFailed++;
               $display("[TB] FAIL full_drop: got level=%0d ovf=%b required 16 1", level, overflow);
            end
         end
      end
      reading_i = 1'b0;
      m_ready   = 1'b1;
      for (int i = 0; i < 16; i++) begin
         exp = (i < 15) ? 32'hB000_0004 + 32'(i) : 32'hB000_0015;
         testsRun++;
         if (m_valid !== 1'b1 || m_data !== exp) begin
            testsFailed++;
            $display("[TB] FAIL full_drain%0d: got valid=%b data=%h required 1 %h", i, m_valid, m_data, exp);
         end
         tick();
      end
      m_ready = 1'b0;
      testsRun++;
      if (level !== 5'd0 || m_valid !== 1'b0 || overflow !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL full_after_drain: got level=%0d valid=%b ovf=%b required 0 0 1", level, m_valid, overflow);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] sbq[$];
      logic [31:0] exp;
      logic [1:0]  rdHist;
      logic        prevS;
      logic        s;
      int          received;
      int          cyc;
      applyReset();
      rdHist    = 2'b00;
      prevS     = 1'b1;
      reading_i = 1'b1;
      received  = 0;
      cyc       = 0;
      while (received < 1000 && cyc < 6000) begin
         cyc++;
         m_ready = cyc[0];
         data_i  = 32'h7700_0000 + 32'(cyc);
         if (m_valid && m_ready) begin
            testsRun++;
            if (sbq.size() == 0) begin
               testsFailed++;
               $display("[TB] FAIL stream_word%0d: got %h required no word (model empty)", received, m_data);
            end else begin
               exp = sbq.pop_front();
               if (m_data !== exp) begin
                  testsFailed++;
                  $display("[TB] FAIL stream_word%0d: got %h required %h", received, m_data, exp);
               end
            end
            received++;
         end
         if (rdHist[1]) begin
            sbq.push_back(data_i);
         end
         rdHist = {rdHist[0], reading_i};
         tick();
         s         = space_ok;
         reading_i = prevS;
         prevS     = s;
      end
      reading_i = 1'b0;
      m_ready   = 1'b0;
      testsRun++;
      if (received < 1000) begin
         testsFailed++;
         $display("[TB] FAIL stream_count: got %0d words required 1000", received);
      end
      testsRun++;
      if (overflow !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL stream_overflow: got %b required 0", overflow);
      end
   endtask

   task automatic test_async_reset();
      applyReset();
      for (int c = 1; c <= 9; c++) begin
         reading_i = 1'b1;
         data_i    = 32'hDEAD_0000 + 32'(c);
         tick();
      end
      testsRun++;
      if (level !== 5'd7) begin
         testsFailed++;
         $display("[TB] FAIL arst_precondition: got level=%0d required 7", level);
      end
      #2;
      reset_    = 1'b0;
      reading_i = 1'b0;
      #1;
      testsRun++;
      if (m_valid !== 1'b0 || level !== 5'd0 || space_ok !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL arst_immediate: got valid=%b level=%0d space_ok=%b required 0 0 1",
                  m_valid, level, space_ok);
      end
      tick();
      reset_ = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         reading_i = (c == 4);
         data_i    = (c == 6) ? 32'hC0DE_0001 : 32'hDEAD_1000 + 32'(c);
         tick();
         if (c == 5) begin
            testsRun++;
            if (level !== 5'd0 || m_valid !== 1'b0) begin
               testsFailed++;
               $display("[TB] FAIL arst_no_stale: got level=%0d valid=%b required 0 0", level, m_valid);
            end
         end
      end
      testsRun++;
      if (level !== 5'd1 || m_valid !== 1'b1 || m_data !== 32'hC0DE_0001) begin
         testsFailed++;
         $display("[TB] FAIL arst_first_word: got level=%0d valid=%b data=%h required 1 1 c0de0001",
                  level, m_valid, m_data);
      end
   endtask

   task automatic test_latency3();
      applyReset();
      for (int c = 1; c <= 25; c++) begin
         reading3 = (c == 20);
         data3    = 32'hD000_0000 + 32'(c);
         tick();
         if (c == 22) begin
            testsRun++;
            if (level3 !== 5'd0) begin
               testsFailed++;
               $display("[TB] FAIL lat3_early: got level=%0d required 0", level3);
            end
         end
         if (c == 23) begin
            testsRun++;
            if (level3 !== 5'd1 || mData3 !== 32'hD000_0017) begin
               testsFailed++;
               $display("[TB] FAIL lat3_sample: got level=%0d data=%h required 1 d0000017", level3, mData3);
            end
         end
         if (c == 24) begin
            testsRun++;
            if (level3 !== 5'd1) begin
               testsFailed++;
               $display("[TB] FAIL lat3_no_repeat: got level=%0d required 1", level3);
            end
         end
      end
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      reset_      = 1'b0;
      reading_i   = 1'b0;
      data_i      = '0;
      m_ready     = 1'b0;
      reading3    = 1'b0;
      data3       = '0;
      test_reset();
      test_latency();
      test_flow_control();
      test_full_push();
      test_back_to_back();
      test_async_reset();
      test_latency3();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
